// File: rtl/dgd_tt_pkg.sv
// Shared types and helpers for the truth-table extractor.
// Bit ordering follows the hex convention: vector 0 lands in the table MSB.
package dgd_tt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        SAMPLE2,
        FINISH
    } tt_state_e;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 2;

    function automatic int tt_bit_idx(input int tt_w, input int i);
        return tt_w - 1 - i;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable up-counter; tc_o flags the last settle cycle of a vector.
// With SETTLE_CYCLES=0 tc_o is permanently high.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = ({1'b0, cnt_q} + 5'd1) >= 5'(SETTLE_CYCLES);

endmodule

// File: rtl/tt_extractor.sv
// Sweeps all input vectors into a combinational netlist and rebuilds its hex truth table.
// Define TT_GLITCH_CHECK_EN to double-sample each vector and flag unstable outputs.
//
// state   | meaning
// IDLE    | waiting for start; results held
// DRIVE   | stim held while the netlist settles
// SAMPLE  | dut_out captured into tt
// SAMPLE2 | second capture, compared with the first (glitch check only)
// FINISH  | match / mismatch_cnt computed, done pulsed on exit
module tt_extractor
    import dgd_tt_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int TT_W          = 2 ** N_IN,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [TT_W-1:0]         expected,
    output logic [N_IN-1:0]         stim,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic [TT_W-1:0]         tt,
    output logic                    match,
`ifdef TT_GLITCH_CHECK_EN
    output logic                    unstable,
`endif
    output logic [$clog2(TT_W):0]   mismatch_cnt
);

    localparam int   CNT_W     = $clog2(TT_W) + 1;
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TT_W - 1);
    localparam bit   NO_SETTLE = (SETTLE_CYCLES == 0);

    tt_state_e          state_q, state_d;
    logic [N_IN:0]      idx_q, idx_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [TT_W-1:0]    exp_q, exp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
`ifdef TT_GLITCH_CHECK_EN
    logic               unstable_q, unstable_d;
`endif

    logic               tmr_load, tmr_en, tmr_tc;
    logic               advance;
    logic [N_IN-1:0]    bit_idx;
    logic [TT_W-1:0]    diff;
    logic [CNT_W-1:0]   popcnt;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    assign bit_idx = N_IN'(tt_bit_idx(TT_W, int'(idx_q)));
    assign diff    = tt_q ^ exp_q;

    always_comb begin
        popcnt = '0;
        for (int k = 0; k < TT_W; k++) begin
            popcnt = popcnt + CNT_W'(diff[k]);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tt_d     = tt_q;
        exp_d    = exp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        match_d  = match_q;
        mcnt_d   = mcnt_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        advance  = 1'b0;
`ifdef TT_GLITCH_CHECK_EN
        unstable_d = unstable_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    tt_d     = '0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    match_d  = 1'b0;
                    mcnt_d   = '0;
                    tmr_load = 1'b1;
`ifdef TT_GLITCH_CHECK_EN
                    unstable_d = 1'b0;
`endif
                    state_d  = NO_SETTLE ? SAMPLE : DRIVE;
                end
            end
            DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_d[bit_idx] = dut_out;
`ifdef TT_GLITCH_CHECK_EN
                state_d = SAMPLE2;
`else
                advance = 1'b1;
`endif
            end
`ifdef TT_GLITCH_CHECK_EN
            SAMPLE2: begin
                if (dut_out != tt_q[bit_idx]) begin
                    unstable_d = 1'b1;
                end
                advance = 1'b1;
            end
`endif
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                mcnt_d  = popcnt;
`ifdef TT_GLITCH_CHECK_EN
                match_d = (diff == '0) && !unstable_q;
`else
                match_d = (diff == '0);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // stim stays on the last vector through FINISH and IDLE
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = FINISH;
            end else begin
                idx_d    = idx_q + 1'b1;
                tmr_load = 1'b1;
                state_d  = NO_SETTLE ? SAMPLE : DRIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            mcnt_q  <= '0;
`ifdef TT_GLITCH_CHECK_EN
            unstable_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            mcnt_q  <= mcnt_d;
`ifdef TT_GLITCH_CHECK_EN
            unstable_q <= unstable_d;
`endif
        end
    end

    assign stim         = idx_q[N_IN-1:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign tt           = tt_q;
    assign match        = match_q;
    assign mismatch_cnt = mcnt_q;
`ifdef TT_GLITCH_CHECK_EN
    assign unstable     = unstable_q;
`endif

endmodule

// File: tb/tb_tt_extractor.sv
// Directed plus randomized bench for tt_extractor: two instances (default settle, zero settle)
// driven by behavioural netlist models; expectations come from a truth-table model.
module tb_tt_extractor;

`ifdef TT_GLITCH_CHECK_EN
    localparam int VEC_EXTRA = 2;
`else
    localparam int VEC_EXTRA = 1;
`endif
    localparam int DONE0 = 16 * (2 + VEC_EXTRA) + 1;
    localparam int DONE1 = 16 * (0 + VEC_EXTRA) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tog = 1'b0;
    logic        glitch = 1'b0;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] exp0 = '0, exp1 = '0;
    logic [3:0]  stim0, stim1;
    logic        dut_out0, dut_out1;
    logic        busy0, busy1, done0, done1, match0, match1;
    logic [15:0] tt0, tt1;
    logic [4:0]  mcnt0, mcnt1;
`ifdef TT_GLITCH_CHECK_EN
    logic        unstable0, unstable1;
`endif

    int          mode0 = 0, mode1 = 2;
    logic [15:0] lut0 = '0, lut1 = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    // mode 0: reference gate function, 1: lookup indexed by input value, 2: tied high
    function automatic logic dut_model(input int mode, input logic [15:0] lut, input logic [3:0] s);
        logic a0, a1, a2, a3;
        a0 = s[3]; a1 = s[2]; a2 = s[1]; a3 = s[0];
        case (mode)
            0:       return (a0 & a2) ^ ((a0 | a2) & a1 & ~a3);
            1:       return lut[s];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] model_tt(input int mode, input logic [15:0] lut);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[15-i] = dut_model(mode, lut, 4'(i));
        return r;
    endfunction

    assign dut_out0 = dut_model(mode0, lut0, stim0) ^ (glitch & (stim0 == 4'd5) & tog);
    assign dut_out1 = dut_model(mode1, lut1, stim1);

    tt_extractor u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .stim(stim0),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .tt(tt0), .match(match0),
`ifdef TT_GLITCH_CHECK_EN
        .unstable(unstable0),
`endif
        .mismatch_cnt(mcnt0)
    );

    tt_extractor #(.SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .stim(stim1),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .tt(tt1), .match(match1),
`ifdef TT_GLITCH_CHECK_EN
        .unstable(unstable1),
`endif
        .mismatch_cnt(mcnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called #1 after the edge that accepted start; n = edges until done is seen.
    task automatic wait_done0(input int repulse_at, input int rst_at, output int n);
        n = 0;
        check("busy0_after_start", 32'(busy0), 1);
        while (!done0 && n < 300) begin
            start0 = (n == repulse_at);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy0), 0);
                check("rst_tt", 32'(tt0), 0);
                check("rst_stim", 32'(stim0), 0);
                check("rst_done", 32'(done0), 0);
                repeat (3) @(posedge clk);
                #1;
                check("rst_no_done", 32'(done0), 0);
                rst_n = 1'b1;
                n = -1;
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start0 = 1'b0;
    endtask

    task automatic sweep0(input logic [15:0] e, input int repulse_at, input int rst_at, output int n);
        @(posedge clk);
        #1;
        exp0 = e;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done0(repulse_at, rst_at, n);
    endtask

    task automatic check_result0(input string tag, input logic [15:0] e, input int n);
        logic [15:0] t;
        t = model_tt(mode0, lut0);
        check({tag, "_cycles"}, 32'(n), DONE0);
        check({tag, "_tt"}, 32'(tt0), 32'(t));
        check({tag, "_match"}, 32'(match0), 32'(t == e));
        check({tag, "_mcnt"}, 32'(mcnt0), 32'($countones(t ^ e)));
        check({tag, "_busy"}, 32'(busy0), 0);
    endtask

    initial begin
        int n;
        logic [15:0] e;

        #2;
        check("reset_busy", 32'(busy0), 0);
        check("reset_done", 32'(done0), 0);
        check("reset_tt", 32'(tt0), 0);
        check("reset_stim", 32'(stim0), 0);
        check("reset_match", 32'(match0), 0);
        check("reset_mcnt", 32'(mcnt0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reference function, exact and one-bit-off golden tables
        mode0 = 0;
        sweep0(16'h0239, -1, -1, n);
        check_result0("f0239", 16'h0239, n);
        check("f0239_tt_const", 32'(tt0), 32'h0239);
        check("f0239_match_const", 32'(match0), 1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done0), 0);
        check("tt_held", 32'(tt0), 32'h0239);

        sweep0(16'h0238, -1, -1, n);
        check_result0("f0238", 16'h0238, n);
        check("f0238_mcnt_const", 32'(mcnt0), 1);

        // start on the done cycle is accepted immediately
        sweep0(16'h0239, -1, -1, n);
        exp0 = 16'hFFFF;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("restart_on_done_tt_clr", 32'(tt0), 0);
        wait_done0(-1, -1, n);
        check_result0("restart_on_done", 16'hFFFF, n);

        // re-pulsed start is ignored
        sweep0(16'h0239, 10, -1, n);
        check_result0("repulse", 16'h0239, n);

        // reset mid-sweep
        sweep0(16'h0239, -1, 20, n);
        check("rst_mid_flag", 32'(n), 32'hFFFFFFFF);
        check("rst_mid_match", 32'(match0), 0);

        // random lookup functions against random golden tables
        mode0 = 1;
        for (int r = 0; r < 4; r++) begin
            lut0 = 16'($urandom);
            e = model_tt(1, lut0);
            if (r != 0) e = e ^ (16'($urandom) & 16'($urandom));
            sweep0(e, -1, -1, n);
            check_result0("rand", e, n);
        end

        // zero-settle instance, tied high: one vector per cycle, visited in order
        @(posedge clk);
        #1;
        exp1 = 16'hFFFF;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 300) begin
            check("s0_stim_order", 32'(stim1), 32'((n / VEC_EXTRA) > 15 ? 15 : (n / VEC_EXTRA)));
            @(posedge clk);
            #1;
            n++;
        end
        check("s0_cycles", 32'(n), DONE1);
        check("s0_tt", 32'(tt1), 32'hFFFF);
        check("s0_match", 32'(match1), 1);
        check("s0_mcnt", 32'(mcnt1), 0);
        check("s0_stim_last", 32'(stim1), 15);

`ifdef TT_GLITCH_CHECK_EN
        mode0 = 0;
        glitch = 1'b1;
        sweep0(16'h0239, -1, -1, n);
        check("glitch_cycles", 32'(n), DONE0);
        check("glitch_unstable", 32'(unstable0), 1);
        check("glitch_match", 32'(match0), 0);
        glitch = 1'b0;
        sweep0(16'h0239, -1, -1, n);
        check("clean_unstable", 32'(unstable0), 0);
        check("clean_match", 32'(match0), 1);
        check("clean_tt", 32'(tt0), 32'h0239);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
